// File: rtl/less_distance_pkg.sv
// Shared constants and types for the less_distance nearest-match selector.
package less_distance_pkg;

  localparam int WIDTH = 8;

  typedef logic [WIDTH-1:0] word_t;

endpackage

// File: rtl/abs_diff.sv
// Unsigned absolute difference |x - y| without wrap-around.
module abs_diff #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] z
);

  logic [WIDTH:0] diff;
  logic [WIDTH:0] diff_rev;
  logic           borrow;

  // The extra top bit is the borrow; when set, x < y and the subtraction order flips.
  assign diff     = {1'b0, x} - {1'b0, y};
  assign diff_rev = {1'b0, y} - {1'b0, x};
  assign borrow   = diff[WIDTH];
  assign z        = borrow ? diff_rev[WIDTH-1:0] : diff[WIDTH-1:0];

endmodule

// File: rtl/less_distance.sv
// Registers whichever of data_a/data_b is closer to reff; ties resolve to data_a.
module less_distance
  import less_distance_pkg::*;
#(
  parameter int WIDTH = less_distance_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] reff,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             out_valid,
  output logic [WIDTH-1:0] data_out,
  output logic             sel_b,
  output logic [WIDTH-1:0] dist_out
);

  logic [WIDTH-1:0] dist_a;
  logic [WIDTH-1:0] dist_b;
  logic             take_b;
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] sel_dist;

  abs_diff #(.WIDTH(WIDTH)) u_dist_a (.x(data_a), .y(reff), .z(dist_a));
  abs_diff #(.WIDTH(WIDTH)) u_dist_b (.x(data_b), .y(reff), .z(dist_b));

  // Strict compare so equal distances keep data_a.
  assign take_b   = dist_b < dist_a;
  assign sel_data = take_b ? data_b : data_a;
  assign sel_dist = take_b ? dist_b : dist_a;

  // Valid-only interface, no backpressure: a result is registered for every
  // cycle in_valid is high and shows one cycle later with out_valid high;
  // while out_valid is low the data outputs hold their last captured values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      sel_b     <= 1'b0;
      dist_out  <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        data_out <= sel_data;
        sel_b    <= take_b;
        dist_out <= sel_dist;
      end
    end
  end

endmodule

// File: tb/tb_less_distance.sv
// Directed plus short random bench for less_distance with an expected-result queue.
module tb_less_distance;
  import less_distance_pkg::*;

  localparam int W = less_distance_pkg::WIDTH;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  word_t        reff;
  word_t        data_a;
  word_t        data_b;
  logic         out_valid;
  word_t        data_out;
  logic         sel_b;
  word_t        dist_out;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Packed expected result: {data, sel_b, dist}.
  logic [2*W:0] exp_q[$];
  logic [2*W:0] hold;

  less_distance #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .reff     (reff),
    .data_a   (data_a),
    .data_b   (data_b),
    .out_valid(out_valid),
    .data_out (data_out),
    .sel_b    (sel_b),
    .dist_out (dist_out)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2*W:0] model(input word_t r, input word_t a, input word_t b);
    int ir, ia, ib, da, db;
    ir = int'(r);
    ia = int'(a);
    ib = int'(b);
    da = (ia >= ir) ? ia - ir : ir - ia;
    db = (ib >= ir) ? ib - ir : ir - ib;
    if (db < da) return {b, 1'b1, word_t'(db)};
    else         return {a, 1'b0, word_t'(da)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, then check outputs just after the edge.
  task automatic step(input logic rst, input logic v, input word_t r, input word_t a, input word_t b);
    logic exp_v;
    rst_n    = rst;
    in_valid = v;
    reff     = r;
    data_a   = a;
    data_b   = b;
    exp_v    = rst & v;
    if (exp_v) exp_q.push_back(model(r, a, b));
    @(posedge clk);
    #1;
    chk("out_valid", {31'b0, out_valid}, {31'b0, exp_v});
    if (!rst) begin
      exp_q.delete();
      hold = '0;
    end else if (exp_v) begin
      chk("sb_depth", exp_q.size(), 1);
      if (exp_q.size() > 0) hold = exp_q.pop_front();
    end
    chk("data_out", {24'b0, data_out}, {24'b0, hold[2*W:W+1]});
    chk("sel_b",    {31'b0, sel_b},    {31'b0, hold[W]});
    chk("dist_out", {24'b0, dist_out}, {24'b0, hold[W-1:0]});
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    reff     = '0;
    data_a   = '0;
    data_b   = '0;
    hold     = '0;

    // Reset held with valid traffic present
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, word_t'($urandom_range(0, 255)),
           word_t'($urandom_range(0, 255)), word_t'($urandom_range(0, 255)));

    // Tie at zero
    step(1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
    // A closer, then B closer
    step(1'b1, 1'b1, 8'h07, 8'h0A, 8'h00);
    step(1'b1, 1'b1, 8'h07, 8'h0A, 8'h05);
    // Extreme range, no wrap
    step(1'b1, 1'b1, 8'h80, 8'h00, 8'hFF);
    step(1'b1, 1'b1, 8'hFF, 8'h00, 8'h01);
    step(1'b1, 1'b1, 8'h00, 8'hFF, 8'hFE);
    // Tie across reference, and equal operands
    step(1'b1, 1'b1, 8'h10, 8'h0C, 8'h14);
    step(1'b1, 1'b1, 8'h33, 8'h5A, 8'h5A);
    // Drop valid: outputs hold
    step(1'b1, 1'b0, 8'h01, 8'h02, 8'h03);
    step(1'b1, 1'b0, 8'hAA, 8'h55, 8'h11);
    // Back-to-back random traffic
    for (int i = 0; i < 20; i++)
      step(1'b1, 1'($urandom_range(0, 3) != 0), word_t'($urandom_range(0, 255)),
           word_t'($urandom_range(0, 255)), word_t'($urandom_range(0, 255)));
    // Mid-stream reset with valid high, then recovery
    step(1'b1, 1'b1, 8'h20, 8'h30, 8'h18);
    step(1'b0, 1'b1, 8'h40, 8'h41, 8'h3E);
    step(1'b1, 1'b1, 8'h40, 8'h41, 8'h3E);
    step(1'b1, 1'b0, 8'h00, 8'h00, 8'h00);

    chk("sb_drain", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/less_distance.md
Name: less_distance

Overview:
- Selects whichever of two unsigned operands, data_a or data_b, is numerically closer to a reference value reff. Registers the chosen operand, which is then presented on data_out.
- Used as a nearest-match selector in datapath compare stages.
- Single clock domain; one-cycle registered latency; valid-qualified.

Parameters:
- WIDTH, 8, bit width of reff, data_a, data_b, data_out and distance outputs.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operands valid this cycle.
- reff  input  WIDTH  unsigned reference value.
- data_a  input  WIDTH  unsigned candidate A.
- data_b  input  WIDTH  unsigned candidate B.
- out_valid  output  1  data_out/sel_b/dist_out valid.
- data_out  output  WIDTH  candidate closer to reff.
- sel_b  output  1  1 when data_b was chosen, 0 when data_a was chosen.
- dist_out  output  WIDTH  absolute distance of the chosen candidate to reff.

Behaviour:
- Distance: dist_x = |x − reff|, computed on unsigned values with no wrap-around.
  - Compute x − reff at WIDTH+1 bits and use the borrow bit to pick the operand order.
  - The result always fits in WIDTH bits; maximum 2^WIDTH − 1.
- Selection: choose B only if dist_b < dist_a (strict compare).
  - Tie (dist_a == dist_b): choose A, sel_b=0.
  - data_a == data_b: output that value, sel_b=0.
- Combinational path: two abs-distance units, one magnitude comparator, one WIDTH-bit 2:1 mux for the value, one mux for the distance.
- Registers, updated on the rising edge of clk:
  - rst_n=0: out_valid←0, data_out←0, sel_b←0, dist_out←0. Reset takes priority over in_valid.
  - rst_n=1 and in_valid=1: capture the selected value, sel_b and distance; out_valid←1.
  - rst_n=1 and in_valid=0: out_valid←0; data_out/sel_b/dist_out hold their last values.
- Latency: operands sampled at edge N appear at edge N+1 outputs. Throughput is one result per cycle; there is no backpressure.
- Reset mid-stream: any in-flight result is discarded; the first valid result after reset deasserts follows one cycle after in_valid.
- Inputs are not checked for X; the behaviour with all operands zero is defined by the tie rule.

Decomposition:
- Package less_distance_pkg: default WIDTH constant. No typedefs beyond a logic [WIDTH-1:0] alias, word_t.
- Sub-module abs_diff (parameter WIDTH; inputs x, y; output |x − y|). Instantiate it twice for dist_a and dist_b.
- Top module: comparator, muxes and output registers.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 and random operands -> out_valid=0, data_out=0x00, sel_b=0, dist_out=0x00 throughout.
- Tie at zero: reff=0x00, A=0x00, B=0x00, in_valid=1 -> next cycle data_out=0x00, sel_b=0, dist_out=0x00, out_valid=1.
- A closer: reff=0x07, A=0x0A, B=0x00 -> data_out=0x0A, sel_b=0, dist_out=0x03. Then B=0x05 -> data_out=0x05, sel_b=1, dist_out=0x02.
- Extreme range, no wrap: reff=0x80, A=0x00, B=0xFF -> data_out=0xFF, sel_b=1, dist_out=0x7F. Also reff=0xFF, A=0x00, B=0x01 -> data_out=0x01, dist_out=0xFE.
- Tie across reference: reff=0x10, A=0x0C, B=0x14 -> data_out=0x0C, sel_b=0, dist_out=0x04.
- Valid gating and mid-stream reset: back-to-back valid cycles give per-cycle results one cycle late. Drop in_valid -> out_valid=0 and data_out holds. Assert rst_n=0 while in_valid=1 -> next edge clears all outputs.
